// File: rtl/ahb_cmd_master_if.sv
// Command-stream and AHB-Lite signal bundle for ahb_cmd_master.
// The master modport is the bus-master view; the slave modport is the command source / AHB slave view.
interface ahb_cmd_master_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_write;
  logic [2:0]    cmd_size;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [3:0]    hprot;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] hrdata;
  logic          hready;
  logic          hresp;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata, hrdata, hready, hresp,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata, hrdata, hready, hresp,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata
  );
endinterface

// File: rtl/ahb_cmd_master.sv
// AHB-Lite master turning valid/ready commands into pipelined NONSEQ SINGLE transfers.
// Define AHB_MST_TIMEOUT_EN to add the sticky wait-state timeout monitor (timeout_flag).
module ahb_cmd_master #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
`ifdef AHB_MST_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT   = 16
`endif
) (
  input  logic             hclk,
  input  logic             hresetn,
  ahb_cmd_master_if.master bus,
  output logic             timeout_flag
);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic {S_RUN, S_ERR_HOLD} state_t;

  state_t        r_state;
  logic          r_aph_valid;
  logic [AW-1:0] r_haddr;
  logic          r_hwrite;
  logic [2:0]    r_hsize;
  logic [DW-1:0] r_aph_wdata;
  logic          r_retained;
  logic          r_dph_valid;
  logic          r_dph_write;
  logic [DW-1:0] r_hwdata;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;
  logic          r_rsp_err;

  logic w_cmd_ready;
  logic w_accept;
  logic w_aph_done;
  logic w_dph_done;
  logic w_err_first;

  assign w_cmd_ready = bus.hready & (r_state == S_RUN);
  assign w_accept    = bus.cmd_valid & w_cmd_ready;
  assign w_aph_done  = r_aph_valid & bus.hready;
  assign w_dph_done  = r_dph_valid & bus.hready;
  assign w_err_first = (r_state == S_RUN) & r_dph_valid & bus.hresp & ~bus.hready;

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_state     <= S_RUN;
      r_aph_valid <= 1'b0;
      r_haddr     <= '0;
      r_hwrite    <= 1'b0;
      r_hsize     <= 3'b010;
      r_aph_wdata <= '0;
      r_retained  <= 1'b0;
      r_dph_valid <= 1'b0;
      r_dph_write <= 1'b0;
      r_hwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_dph_done;
      r_rsp_rdata <= (w_dph_done && !r_dph_write) ? bus.hrdata : '0;
      r_rsp_err   <= w_dph_done & bus.hresp;

      // Data phase advances only on hready; wait states leave hwdata untouched.
      if (bus.hready) begin
        r_dph_valid <= r_aph_valid;
        if (r_aph_valid) begin
          r_dph_write <= r_hwrite;
          r_hwdata    <= r_aph_wdata;
        end
      end

      // Address fields are never cleared: the slave decodes hrdata from the live haddr.
      case (r_state)
        S_RUN: begin
          if (w_err_first) begin
            r_state     <= S_ERR_HOLD;
            r_retained  <= r_aph_valid;
            r_aph_valid <= 1'b0;
          end else if (w_accept) begin
            r_aph_valid <= 1'b1;
            r_haddr     <= bus.cmd_addr;
            r_hwrite    <= bus.cmd_write;
            r_hsize     <= bus.cmd_size;
            r_aph_wdata <= bus.cmd_wdata;
          end else if (w_aph_done) begin
            r_aph_valid <= 1'b0;
          end
        end
        S_ERR_HOLD: begin
          // Second ERROR cycle: re-issue whatever was cancelled on the first one.
          if (bus.hready) begin
            r_state     <= S_RUN;
            r_aph_valid <= r_retained;
            r_retained  <= 1'b0;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

`ifdef AHB_MST_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] r_wait_cnt;
  logic            r_timeout_flag;

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_wait_cnt     <= '0;
      r_timeout_flag <= 1'b0;
    end else if (r_dph_valid && !bus.hready) begin
      if (r_wait_cnt != TO_W'(TIMEOUT)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (r_wait_cnt == TO_W'(TIMEOUT - 1)) begin
        r_timeout_flag <= 1'b1;
      end
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign timeout_flag = r_timeout_flag;
`else
  assign timeout_flag = 1'b0;
`endif

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.hsel      = r_aph_valid;
  assign bus.htrans    = r_aph_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.haddr     = r_haddr;
  assign bus.hwrite    = r_hwrite;
  assign bus.hsize     = r_hsize;
  assign bus.hburst    = 3'b000;
  assign bus.hprot     = HPROT_VAL;
  assign bus.hwdata    = r_hwdata;
endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master; the slave is modelled inline with hrdata = live haddr.
module tb_ahb_cmd_master;
  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  logic timeout_flag;
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef AHB_MST_TIMEOUT_EN
  localparam logic [31:0] TO_EXP = 32'd1;
`else
  localparam logic [31:0] TO_EXP = 32'd0;
`endif

  ahb_cmd_master_if #(.AW(32), .DW(32)) bus ();

  ahb_cmd_master #(.AW(32), .DW(32)) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .bus         (bus),
    .timeout_flag(timeout_flag)
  );

  always #5 hclk = ~hclk;

  assign bus.hrdata = bus.haddr;

  always @(posedge hclk) begin
    if (bus.rsp_valid)
      $display("[%0t] rsp rdata=%h err=%0b", $time, bus.rsp_rdata, bus.rsp_err);
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                      input logic [31:0] wd);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_write = wr;
    bus.cmd_size  = sz;
    bus.cmd_wdata = wd;
    $display("[%0t] cmd addr=%h write=%0b size=%0d wdata=%h", $time, addr, wr, sz, wd);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_write = 1'b0;
    bus.cmd_size  = 3'b010;
    bus.cmd_wdata = '0;
    bus.hready    = 1'b1;
    bus.hresp     = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_htrans", 32'(bus.htrans), 32'd0);
    chk("rst_hsel", 32'(bus.hsel), 32'd0);
    chk("rst_haddr", bus.haddr, 32'd0);
    chk("rst_hwrite", 32'(bus.hwrite), 32'd0);
    chk("rst_hsize", 32'(bus.hsize), 32'd2);
    chk("rst_hwdata", bus.hwdata, 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_timeout", 32'(timeout_flag), 32'd0);
    chk("rst_hburst", 32'(bus.hburst), 32'd0);
    chk("rst_hprot", 32'(bus.hprot), 32'h3);
    hresetn = 1'b1;
    tick();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Write 0x00030005 to 0x4, then read 0x8
    send(32'h4, 1'b1, 3'b010, 32'h0003_0005);
    tick();
    chk("t1_htrans_w", 32'(bus.htrans), 32'h2);
    chk("t1_hsel_w", 32'(bus.hsel), 32'd1);
    chk("t1_haddr_w", bus.haddr, 32'h4);
    chk("t1_hwrite_w", 32'(bus.hwrite), 32'd1);
    send(32'h8, 1'b0, 3'b000, 32'hDEAD_BEEF);
    tick();
    chk("t1_haddr_r", bus.haddr, 32'h8);
    chk("t1_hsize_r", 32'(bus.hsize), 32'd0);
    chk("t1_hwrite_r", 32'(bus.hwrite), 32'd0);
    chk("t1_hwdata", bus.hwdata, 32'h0003_0005);
    chk("t1_rsp_early", 32'(bus.rsp_valid), 32'd0);
    bus.cmd_valid = 1'b0;
    tick();
    chk("t1_rsp_w_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t1_rsp_w_err", 32'(bus.rsp_err), 32'd0);
    chk("t1_rsp_w_rdata", bus.rsp_rdata, 32'd0);
    chk("t1_idle_htrans", 32'(bus.htrans), 32'd0);
    chk("t1_idle_hsel", 32'(bus.hsel), 32'd0);
    chk("t1_idle_haddr", bus.haddr, 32'h8);
    tick();
    chk("t1_rsp_r_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t1_rsp_r_rdata", bus.rsp_rdata, 32'h0000_0008);
    tick();
    chk("t1_rsp_end", 32'(bus.rsp_valid), 32'd0);

    // Four back-to-back writes
    for (int i = 0; i < 4; i++) begin
      send(32'h4, 1'b1, 3'b010, 32'h100 + 32'(i));
      tick();
      chk("t2_htrans", 32'(bus.htrans), 32'h2);
      chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'(i >= 2));
      if (i >= 1) chk("t2_hwdata", bus.hwdata, 32'h100 + 32'(i) - 32'd1);
    end
    bus.cmd_valid = 1'b0;
    tick();
    chk("t2_tail_htrans", 32'(bus.htrans), 32'd0);
    chk("t2_tail_rsp3", 32'(bus.rsp_valid), 32'd1);
    chk("t2_tail_hwdata", bus.hwdata, 32'h103);
    tick();
    chk("t2_tail_rsp4", 32'(bus.rsp_valid), 32'd1);
    tick();
    chk("t2_tail_end", 32'(bus.rsp_valid), 32'd0);

    // Two wait states during a data phase with a queued address phase
    send(32'h10, 1'b1, 3'b010, 32'hA5A5_0001);
    tick();
    send(32'h14, 1'b1, 3'b010, 32'hA5A5_0002);
    tick();
    bus.cmd_valid = 1'b0;
    bus.hready    = 1'b0;
    #1;
    chk("t3_ready_w1", 32'(bus.cmd_ready), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("t3_hwdata_hold", bus.hwdata, 32'hA5A5_0001);
      chk("t3_haddr_hold", bus.haddr, 32'h14);
      chk("t3_htrans_hold", 32'(bus.htrans), 32'h2);
      chk("t3_no_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("t3_ready_low", 32'(bus.cmd_ready), 32'd0);
    end
    bus.hready = 1'b1;
    tick();
    chk("t3_rsp1", 32'(bus.rsp_valid), 32'd1);
    chk("t3_rsp1_err", 32'(bus.rsp_err), 32'd0);
    chk("t3_idle", 32'(bus.htrans), 32'd0);
    chk("t3_hwdata2", bus.hwdata, 32'hA5A5_0002);
    tick();
    chk("t3_rsp2", 32'(bus.rsp_valid), 32'd1);
    tick();

    // ERROR on write A with write B queued in the address phase
    send(32'h20, 1'b1, 3'b010, 32'hAAAA_0000);
    tick();
    send(32'h24, 1'b1, 3'b010, 32'hBBBB_0000);
    tick();
    bus.cmd_valid = 1'b0;
    bus.hresp     = 1'b1;
    bus.hready    = 1'b0;
    tick();
    chk("t4_err1_htrans", 32'(bus.htrans), 32'd0);
    chk("t4_err1_hsel", 32'(bus.hsel), 32'd0);
    bus.hready = 1'b1;
    #1;
    chk("t4_err2_ready", 32'(bus.cmd_ready), 32'd0);
    chk("t4_err2_no_rsp", 32'(bus.rsp_valid), 32'd0);
    tick();
    bus.hresp = 1'b0;
    chk("t4_a_rsp", 32'(bus.rsp_valid), 32'd1);
    chk("t4_a_err", 32'(bus.rsp_err), 32'd1);
    chk("t4_b_htrans", 32'(bus.htrans), 32'h2);
    chk("t4_b_hsel", 32'(bus.hsel), 32'd1);
    chk("t4_b_haddr", bus.haddr, 32'h24);
    #1;
    chk("t4_ready_back", 32'(bus.cmd_ready), 32'd1);
    tick();
    chk("t4_b_idle", 32'(bus.htrans), 32'd0);
    chk("t4_b_hwdata", bus.hwdata, 32'hBBBB_0000);
    chk("t4_gap", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("t4_b_rsp", 32'(bus.rsp_valid), 32'd1);
    chk("t4_b_err", 32'(bus.rsp_err), 32'd0);
    tick();

    // Reset during a wait state drops the in-flight command
    send(32'h30, 1'b1, 3'b010, 32'h3333_3333);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    bus.hready = 1'b0;
    tick();
    hresetn = 1'b0;
    tick();
    chk("t5_htrans", 32'(bus.htrans), 32'd0);
    chk("t5_haddr", bus.haddr, 32'd0);
    chk("t5_hwdata", bus.hwdata, 32'd0);
    chk("t5_rsp", 32'(bus.rsp_valid), 32'd0);
    hresetn = 1'b1;
    bus.hready = 1'b1;
    tick();
    chk("t5_no_rsp", 32'(bus.rsp_valid), 32'd0);

    // Sixteen consecutive wait states
    send(32'h40, 1'b0, 3'b010, 32'd0);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    bus.hready = 1'b0;
    repeat (15) tick();
    chk("t6_to_15", 32'(timeout_flag), 32'd0);
    tick();
    chk("t6_to_16", 32'(timeout_flag), TO_EXP);
    bus.hready = 1'b1;
    tick();
    chk("t6_rsp", 32'(bus.rsp_valid), 32'd1);
    chk("t6_rdata", bus.rsp_rdata, 32'h40);
    tick();
    chk("t6_sticky", 32'(timeout_flag), TO_EXP);
    hresetn = 1'b0;
    tick();
    chk("t6_rst_clear", 32'(timeout_flag), 32'd0);
    hresetn = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
